// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and the instruction-fetch handshake.
// Issues fetch requests, fills the IF/ID register, parks one extra word in a skid
// buffer while ID is stalled, drops wrong-path data on redirect and stops on HALT.
module fetch_sequencer #(
   parameter int                PC_W     = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter int                PC_INC   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pcsrc,
   input  logic [PC_W-1:0]    branch_target,
   input  logic               stall,
   input  logic               halt_in,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   output logic               flush,
   output logic               halted
);

   localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

   typedef enum logic [2:0] {
      S_BOOT,
      S_FETCH,
      S_HOLD,
      S_DISCARD,
      S_HALT
   } state_t;

   state_t state, state_n;

   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;
   logic               skid_vld;
   logic               halt_pend, halt_pend_n;

   logic ack;        // response accepted this cycle
   logic id_free;    // IF/ID can take a new word at this edge
   logic redir;      // redirect takes effect at this edge
   logic halt_req;   // halt requested (now or earlier) and not cancelled
   logic load_if;    // load fetched word straight into IF/ID
   logic load_skid;  // park fetched word in the skid buffer
   logic pop_skid;   // move skid word into IF/ID
   logic pc_inc;     // advance pc past an accepted word
   logic halt_go;    // entering HALT at this edge

   assign imem_req  = (state == S_FETCH) || (state == S_DISCARD);
   assign imem_addr = pc;
   assign halted    = (state == S_HALT);

   assign ack      = imem_req && imem_ack;
   assign id_free  = !if_valid || !stall;
   assign redir    = pcsrc && (state != S_HALT);
   assign halt_req = (halt_in || halt_pend) && !pcsrc;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_BOOT;
      else     state <= state_n;
   end

   // next state and datapath control; redirect outranks halt, halt outranks fetch
   always_comb begin
      state_n     = state;
      halt_pend_n = halt_pend;
      load_if     = 1'b0;
      load_skid   = 1'b0;
      pop_skid    = 1'b0;
      pc_inc      = 1'b0;
      halt_go     = 1'b0;
      if (state == S_HALT) begin
         state_n = S_HALT;
      end else if (redir) begin
         // a request still in flight returns old-path data, so it must be drained
         if (imem_req && !ack) state_n = S_DISCARD;
         else                  state_n = S_FETCH;
         halt_pend_n = 1'b0;
      end else if (halt_req) begin
         if (imem_req && !ack) begin
            // request cannot be withdrawn; wait for its response and drop it
            halt_pend_n = 1'b1;
         end else begin
            state_n     = S_HALT;
            halt_pend_n = 1'b0;
            halt_go     = 1'b1;
         end
      end else begin
         case (state)
            S_BOOT: state_n = S_FETCH;
            S_FETCH: begin
               if (ack) begin
                  pc_inc = 1'b1;
                  if (id_free) begin
                     load_if = 1'b1;
                  end else begin
                     load_skid = 1'b1;
                     state_n   = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  pop_skid = skid_vld;
                  state_n  = S_FETCH;
               end
            end
            S_DISCARD: begin
               if (ack) state_n = S_FETCH;
            end
            default: state_n = S_BOOT;
         endcase
      end
   end

   // program counter: redirect target, or advance past each accepted word (wraps)
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         pc <= RESET_PC;
      else if (redir)  pc <= branch_target;
      else if (pc_inc) pc <= pc + INC;
   end

   // IF/ID register: load new word, take skid word, or go empty when consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
      end else if (redir || halt_go) begin
         if_valid <= 1'b0;
      end else if (load_if) begin
         if_valid <= 1'b1;
         if_instr <= imem_rdata;
         if_pc    <= pc;
      end else if (pop_skid) begin
         if_valid <= 1'b1;
         if_instr <= skid_instr;
         if_pc    <= skid_pc;
      end else if (if_valid && !stall) begin
         if_valid <= 1'b0;
      end
   end

   // skid buffer: holds the word that arrived while ID was blocked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_vld   <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (redir || halt_go) begin
         skid_vld <= 1'b0;
      end else if (load_skid) begin
         skid_vld   <= 1'b1;
         skid_instr <= imem_rdata;
         skid_pc    <= pc;
      end else if (pop_skid) begin
         skid_vld <= 1'b0;
      end
   end

   // remembers a halt that is waiting for an in-flight response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) halt_pend <= 1'b0;
      else     halt_pend <= halt_pend_n;
   end

   // flush pulses the cycle after each redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) flush <= 1'b0;
      else     flush <= redir;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a queue-based reference model
// checked every cycle, plus literal spot checks at the key points.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pcsrc = 1'b0;
   logic [15:0] branch_target = '0;
   logic        stall = 1'b0;
   logic        halt_in = 1'b0;
   logic        imem_req, imem_ack;
   logic [15:0] imem_addr, imem_rdata;
   logic        if_valid, flush, halted;
   logic [15:0] if_instr, if_pc;

   int tests = 0;
   int fails = 0;

   // memory: acks once a request has waited lat cycles
   bit ack_en = 1'b1;
   int lat = 0;
   int wcnt = 0;

   function automatic logic [15:0] memf(input logic [15:0] a);
      return 16'hA000 + {1'b0, a[15:1]};
   endfunction

   assign imem_ack   = imem_req && ack_en && (wcnt >= lat);
   assign imem_rdata = memf(imem_addr);

   always #5 clk = ~clk;

   fetch_sequencer #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_INC(2)) dut (
      .clk(clk), .rst(rst), .pcsrc(pcsrc), .branch_target(branch_target),
      .stall(stall), .halt_in(halt_in), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
      .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .halted(halted)
   );

   // reference model: pipeline contents as a queue (head = IF/ID, second = parked word)
   bit          m_boot = 1'b1, m_halted = 1'b0, m_hpend = 1'b0, m_stale = 1'b0, m_flush = 1'b0;
   logic [15:0] m_pc = 16'h0000;
   logic [15:0] q_pc[$];
   logic [15:0] q_in[$];

   function automatic bit m_req();
      return !m_boot && !m_halted && (q_pc.size() < 2);
   endfunction

   task automatic chk1(input string n, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
      end
   endtask

   task automatic chk16(input string n, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin : model
      bit r, a;
      if (rst) begin
         m_boot = 1'b1; m_halted = 1'b0; m_hpend = 1'b0; m_stale = 1'b0; m_flush = 1'b0;
         m_pc = 16'h0000;
         q_pc.delete(); q_in.delete();
         wcnt <= 0;
      end else begin
         r = m_req();
         a = r && ack_en && (wcnt >= lat);
         m_flush = 1'b0;
         if (m_halted) begin
            m_halted = 1'b1;
         end else if (pcsrc) begin
            m_pc = branch_target;
            q_pc.delete(); q_in.delete();
            m_flush = 1'b1;
            m_stale = r && !a;
            m_boot  = 1'b0;
            m_hpend = 1'b0;
         end else if (halt_in || m_hpend) begin
            if (r && !a) begin
               m_hpend = 1'b1;
               if (q_pc.size() > 0 && !stall) begin
                  void'(q_pc.pop_front()); void'(q_in.pop_front());
               end
            end else begin
               m_halted = 1'b1;
               m_hpend  = 1'b0;
               m_boot   = 1'b0;
               q_pc.delete(); q_in.delete();
            end
         end else if (m_boot) begin
            m_boot = 1'b0;
         end else begin
            if (q_pc.size() > 0 && !stall) begin
               void'(q_pc.pop_front()); void'(q_in.pop_front());
            end
            if (a) begin
               if (m_stale) m_stale = 1'b0;
               else begin
                  q_pc.push_back(m_pc);
                  q_in.push_back(memf(m_pc));
                  m_pc = m_pc + 16'd2;
               end
            end
         end
         wcnt <= (r && !a) ? wcnt + 1 : 0;
      end
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         chk1("imem_req", imem_req, m_req());
         if (m_req()) chk16("imem_addr", imem_addr, m_pc);
         chk1("if_valid", if_valid, q_pc.size() > 0);
         if (q_pc.size() > 0) begin
            chk16("if_pc", if_pc, q_pc[0]);
            chk16("if_instr", if_instr, q_in[0]);
         end
         chk1("flush", flush, m_flush);
         chk1("halted", halted, m_halted);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", if_valid, 1'b0);
      chk16("rst_instr", if_instr, 16'h0000);
      chk16("rst_ifpc", if_pc, 16'h0000);
      chk1("rst_flush", flush, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      rst = 1'b0;

      // zero-wait streaming
      tick();
      chk1("boot_req", imem_req, 1'b1);
      chk16("boot_addr", imem_addr, 16'h0000);
      chk1("boot_valid", if_valid, 1'b0);
      tick();
      chk16("s_pc0", if_pc, 16'h0000);
      chk16("s_in0", if_instr, 16'hA000);
      tick();
      chk16("s_pc1", if_pc, 16'h0002);
      chk16("s_in1", if_instr, 16'hA001);
      tick(2);
      chk16("s_pc3", if_pc, 16'h0006);
      chk16("s_addr", imem_addr, 16'h0008);

      // stall for three edges with a response arriving
      stall = 1'b1;
      tick();
      chk1("hold_req", imem_req, 1'b0);
      chk16("hold_pc", if_pc, 16'h0006);
      tick(2);
      chk16("hold_pc2", if_pc, 16'h0006);
      stall = 1'b0;
      tick();
      chk16("skid_pc", if_pc, 16'h0008);
      chk16("skid_in", if_instr, 16'hA004);
      chk16("skid_addr", imem_addr, 16'h000A);
      tick();
      chk16("after_pc", if_pc, 16'h000A);
      chk16("after_in", if_instr, 16'hA005);

      // redirect coinciding with an ack
      pcsrc = 1'b1; branch_target = 16'h0040;
      tick();
      pcsrc = 1'b0;
      chk1("r3_flush", flush, 1'b1);
      chk1("r3_valid", if_valid, 1'b0);
      chk16("r3_addr", imem_addr, 16'h0040);
      tick();
      chk1("r3_flush0", flush, 1'b0);
      chk16("r3_pc", if_pc, 16'h0040);
      chk16("r3_in", if_instr, 16'hA020);

      // redirect while a slow request is outstanding
      lat = 2;
      pcsrc = 1'b1; branch_target = 16'h0100;
      tick();
      pcsrc = 1'b0;
      chk1("r4_flush", flush, 1'b1);
      chk1("r4_req", imem_req, 1'b1);
      chk16("r4_addr", imem_addr, 16'h0100);
      tick();
      chk1("r4_req2", imem_req, 1'b1);
      tick();
      chk1("r4_drop", if_valid, 1'b0);
      chk16("r4_addr2", imem_addr, 16'h0100);
      tick(3);
      chk1("r4_valid", if_valid, 1'b1);
      chk16("r4_pc", if_pc, 16'h0100);
      chk16("r4_in", if_instr, 16'hA080);

      // halt with a request outstanding
      halt_in = 1'b1;
      tick();
      chk1("h_pend", halted, 1'b0);
      chk1("h_req", imem_req, 1'b1);
      tick(2);
      halt_in = 1'b0;
      chk1("h_halted", halted, 1'b1);
      chk1("h_req0", imem_req, 1'b0);
      chk1("h_valid", if_valid, 1'b0);
      pcsrc = 1'b1; branch_target = 16'h0300;
      tick();
      pcsrc = 1'b0;
      tick(4);
      chk1("h_stay", halted, 1'b1);
      chk1("h_noreq", imem_req, 1'b0);

      // halt and redirect together: redirect wins
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lat = 0;
      tick();
      halt_in = 1'b1; pcsrc = 1'b1; branch_target = 16'h0200;
      tick();
      halt_in = 1'b0; pcsrc = 1'b0;
      chk1("hr_halted", halted, 1'b0);
      chk1("hr_flush", flush, 1'b1);
      chk16("hr_addr", imem_addr, 16'h0200);
      tick();
      chk16("hr_pc", if_pc, 16'h0200);
      chk16("hr_in", if_instr, 16'hA100);

      // pc wrap at the top of the address space
      pcsrc = 1'b1; branch_target = 16'hFFFE;
      tick();
      pcsrc = 1'b0;
      chk16("w_addr", imem_addr, 16'hFFFE);
      tick();
      chk16("w_pc", if_pc, 16'hFFFE);
      chk16("w_in", if_instr, 16'h1FFF);
      chk16("w_next", imem_addr, 16'h0000);
      tick();
      chk16("w_addr2", imem_addr, 16'h0002);

      // reset in the middle of a slow request
      lat = 3;
      tick(2);
      #2;
      rst = 1'b1;
      #1;
      chk1("mr_req", imem_req, 1'b0);
      chk1("mr_valid", if_valid, 1'b0);
      chk16("mr_addr", imem_addr, 16'h0000);
      chk1("mr_halted", halted, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      lat = 0;
      tick(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
